// File: rtl/capi_mmio_rd_responder.sv
// MMIO read responder: decodes a word address against a register window and
// returns one 64-bit AFU status register (or a replicated 32-bit half) via valid/ack.
module capi_mmio_rd_responder #(
  parameter int          addr_width = 25,
  parameter int          num_regs   = 4,
  parameter int unsigned addr       = 0,
  parameter int unsigned addr_mask  = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [0:addr_width-1]     ra,
  input  logic                      re,
  input  logic                      dw,
  input  logic [0:64*num_regs-1]    rd_regs,
  input  logic                      rack,
  output logic                      rvalid,
  output logic [0:63]               rdata,
  output logic                      busy,
  output logic                      overrun
);
  localparam int regsel_w = $clog2(num_regs);
  localparam int region_w = addr_width - 1 - regsel_w;
  localparam logic [region_w-1:0] addr_r = region_w'(addr);
  localparam logic [region_w-1:0] mask_r = region_w'(addr_mask);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;
  state_t state_q, state_d;

  logic [region_w-1:0] region;
  logic [regsel_w-1:0] regsel, sel_q;
  logic                word, match, accept, dw_q, word_q;
  logic [63:0]         regs [num_regs];
  logic [63:0]         cur, fetched;

  assign region = ra[0:region_w-1];
  assign regsel = ra[region_w:addr_width-2];
  assign word   = ra[addr_width-1];
  assign match  = ((~mask_r & region) == addr_r);

  // reg k occupies big-endian bits [64k : 64k+63] of the flat bus
  for (genvar k = 0; k < num_regs; k++) begin : g_reg
    assign regs[k] = rd_regs[64*k +: 64];
  end

  assign cur     = regs[sel_q];
  assign fetched = dw_q   ? cur :
                   word_q ? {cur[31:0], cur[31:0]} : {cur[63:32], cur[63:32]};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE:    if (re && match) begin
                 state_d = FETCH;
                 accept  = 1'b1;
               end
      FETCH:   state_d = RESP;
      RESP:    if (rack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rvalid  <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      sel_q   <= '0;
      dw_q    <= 1'b0;
      word_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rvalid  <= (state_d == RESP);
      busy    <= (state_d != IDLE);
      // a matched request arriving while a response is in flight is dropped
      if (re && match && state_q != IDLE) overrun <= 1'b1;
      if (accept) begin
        sel_q  <= regsel;
        dw_q   <= dw;
        word_q <= word;
      end
      if (state_q == FETCH) rdata <= fetched;
    end
  end
endmodule

// File: tb/tb_capi_mmio_rd_responder.sv
// Directed bench for capi_mmio_rd_responder: two instances (plain window and masked
// window) checked every cycle against a cycle-count based model plus literal expectations.
module tb_capi_mmio_rd_responder;
  logic        clk = 1'b0;
  logic        reset, re, dw, rack;
  logic [0:24] ra;
  logic [63:0] regs_m [4];
  logic [0:255] rd_regs;
  logic        rvalid_a, busy_a, ovr_a, rvalid_b, busy_b, ovr_b;
  logic [0:63] rdata_a, rdata_b;

  assign rd_regs = {regs_m[0], regs_m[1], regs_m[2], regs_m[3]};

  always #5 clk = ~clk;

  capi_mmio_rd_responder #(.addr_width(25), .num_regs(4), .addr(32'h10), .addr_mask(32'h0)) u_a (
    .clk(clk), .reset(reset), .ra(ra), .re(re), .dw(dw), .rd_regs(rd_regs), .rack(rack),
    .rvalid(rvalid_a), .rdata(rdata_a), .busy(busy_a), .overrun(ovr_a));

  capi_mmio_rd_responder #(.addr_width(25), .num_regs(4), .addr(32'h0), .addr_mask(32'h30)) u_b (
    .clk(clk), .reset(reset), .ra(ra), .re(re), .dw(dw), .rd_regs(rd_regs), .rack(rack),
    .rvalid(rvalid_b), .rdata(rdata_b), .busy(busy_b), .overrun(ovr_b));

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // model: a request accepted in cycle t is sampled in t+1 and valid from t+2 until acked
  int unsigned p_addr [2] = '{32'h10, 32'h0};
  int unsigned p_mask [2] = '{32'h0, 32'h30};
  bit          m_pend [2], m_dw [2], m_word [2], m_ovr [2], m_rvalid [2];
  longint      m_tacc [2];
  int          m_sel  [2];
  logic [63:0] m_data [2];
  longint      cyc = 0;

  function automatic logic [63:0] fmt(input logic [63:0] r, input bit d, input bit w);
    if (d) return r;
    return w ? {r[31:0], r[31:0]} : {r[63:32], r[63:32]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] av;
      bit hit, was;
      av  = 32'(ra);
      hit = re && ((((av >> 3) & ~p_mask[i]) & 32'h3FFFFF) == p_addr[i]);
      if (reset) begin
        m_pend[i] = 0; m_ovr[i] = 0; m_data[i] = '0;
      end else begin
        was = m_pend[i];
        if (was && cyc == m_tacc[i] + 1) m_data[i] = fmt(regs_m[m_sel[i]], m_dw[i], m_word[i]);
        if (was && cyc >= m_tacc[i] + 2 && rack) m_pend[i] = 0;
        if (hit) begin
          if (was) m_ovr[i] = 1;
          else begin
            m_pend[i] = 1; m_tacc[i] = cyc;
            m_sel[i] = int'((av >> 1) & 3); m_dw[i] = dw; m_word[i] = av[0];
          end
        end
      end
      m_rvalid[i] = m_pend[i] && (cyc + 1 >= m_tacc[i] + 2);
    end
    cyc++;
  end

  always @(negedge clk) if (chk_en) begin
    check("a_rvalid", rvalid_a, m_rvalid[0]);
    check("a_busy",   busy_a,   m_pend[0]);
    check("a_ovr",    ovr_a,    m_ovr[0]);
    check("a_rdata",  rdata_a,  m_data[0]);
    check("b_rvalid", rvalid_b, m_rvalid[1]);
    check("b_busy",   busy_b,   m_pend[1]);
    check("b_ovr",    ovr_b,    m_ovr[1]);
    check("b_rdata",  rdata_b,  m_data[1]);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [66:0] outs(input int inst);
    return inst ? {rvalid_b, busy_b, ovr_b, rdata_b} : {rvalid_a, busy_a, ovr_a, rdata_a};
  endfunction

  // single read: re in cycle N, rvalid at N+2, rack at N+3, idle at N+4
  task automatic rd(input logic [24:0] a, input bit d, input int inst,
                    input logic [63:0] exp, input string nm);
    logic [66:0] o;
    ra = a; dw = d; re = 1; tick(); re = 0;
    o = outs(inst); check({nm, "_busy_n1"}, o[65], 1'b1);
    tick();
    o = outs(inst); check({nm, "_rvalid_n2"}, o[66], 1'b1); check({nm, "_rdata"}, o[63:0], exp);
    tick();
    o = outs(inst); check({nm, "_rvalid_n3"}, o[66], 1'b1);
    rack = 1; tick(); rack = 0;
    o = outs(inst); check({nm, "_rvalid_n4"}, o[66], 1'b0); check({nm, "_busy_n4"}, o[65], 1'b0);
  endtask

  initial begin
    reset = 1; re = 0; dw = 0; rack = 0; ra = '0;
    regs_m[0] = 64'h1111111111111111; regs_m[1] = 64'h2222222222222222;
    regs_m[2] = 64'h0123456789ABCDEF; regs_m[3] = 64'h4444444444444444;
    tick(); chk_en = 1; tick(); reset = 0;
    check("rst_rvalid", rvalid_a, 1'b0); check("rst_rdata", rdata_a, 64'h0);
    check("rst_busy", busy_a, 1'b0);     check("rst_ovr", ovr_a, 1'b0);

    rd(25'h84, 1, 0, 64'h0123456789ABCDEF, "rd64");
    rd(25'h85, 0, 0, 64'h89ABCDEF89ABCDEF, "rd32_w1");
    rd(25'h84, 0, 0, 64'h0123456701234567, "rd32_w0");
    rd(25'h86, 1, 0, 64'h4444444444444444, "rd64_reg3");

    // region 0x20 misses the plain window but hits the masked one
    ra = 25'h104; dw = 1; re = 1; tick(); re = 0;
    check("miss_busy", busy_a, 1'b0);
    tick();
    check("miss_rvalid", rvalid_a, 1'b0); check("mask_b_rdata", rdata_b, 64'h0123456789ABCDEF);
    tick(); rack = 1; tick(); rack = 0;
    rd(25'h184, 1, 1, 64'h0123456789ABCDEF, "mask_b");
    check("mask_a_idle", busy_a, 1'b0);

    // overrun: second request in FETCH, third in the rack cycle
    ra = 25'h84; dw = 1; re = 1; tick();
    ra = 25'h85; dw = 0; tick(); re = 0;
    check("ovr_n2", ovr_a, 1'b1); check("ovr_rvalid", rvalid_a, 1'b1);
    check("ovr_rdata", rdata_a, 64'h0123456789ABCDEF);
    tick(); rack = 1; ra = 25'h84; re = 1; tick(); rack = 0; re = 0;
    check("ovr_done_rvalid", rvalid_a, 1'b0); check("ovr_done_busy", busy_a, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick(); check("ovr_single_resp", rvalid_a, 1'b0); check("ovr_held", ovr_a, 1'b1);
    end

    // backpressure with the source register changing under the response
    ra = 25'h84; dw = 1; re = 1; tick(); re = 0; tick();
    for (int j = 0; j < 20; j++) begin
      regs_m[2] = 64'hDEAD000000000000 + 64'(j);
      check("bp_rvalid", rvalid_a, 1'b1); check("bp_rdata", rdata_a, 64'h0123456789ABCDEF);
      tick();
    end
    rack = 1; tick(); rack = 0;
    check("bp_end_rvalid", rvalid_a, 1'b0); check("bp_end_busy", busy_a, 1'b0);
    regs_m[2] = 64'h0123456789ABCDEF;

    // reset asserted during FETCH
    ra = 25'h84; dw = 1; re = 1; tick(); re = 0; reset = 1; tick(); reset = 0;
    check("rmid_rvalid", rvalid_a, 1'b0); check("rmid_rdata", rdata_a, 64'h0);
    check("rmid_busy", busy_a, 1'b0);     check("rmid_ovr", ovr_a, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick(); check("rmid_no_rvalid", rvalid_a, 1'b0);
    end
    rd(25'h85, 0, 0, 64'h89ABCDEF89ABCDEF, "post_rst");
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
